// File: rtl/ervp_fwft_fifo_ctrl_if.sv
// Push/pop handshake and memory-cell port bundle for ervp_fwft_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding logic and cell.
interface ervp_fwft_fifo_ctrl_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BW_INDEX = 2,
  parameter int unsigned BW_COUNT = 3
);
  logic                flush;
  logic                wready;
  logic                wrequest;
  logic [WIDTH-1:0]    wdata;
  logic                rready;
  logic                rrequest;
  logic [WIDTH-1:0]    rdata;
  logic [BW_COUNT-1:0] count;
  logic [BW_INDEX-1:0] mem_windex;
  logic                mem_wenable;
  logic [WIDTH-1:0]    mem_wdata;
  logic [BW_INDEX-1:0] mem_rindex;
  logic                mem_renable;
  logic [WIDTH-1:0]    mem_rdata_synch;

  modport master (
    output flush, wrequest, wdata, rrequest, mem_rdata_synch,
    input  wready, rready, rdata, count,
    input  mem_windex, mem_wenable, mem_wdata, mem_rindex, mem_renable
  );

  modport slave (
    input  flush, wrequest, wdata, rrequest, mem_rdata_synch,
    output wready, rready, rdata, count,
    output mem_windex, mem_wenable, mem_wdata, mem_rindex, mem_renable
  );
endinterface

// File: rtl/ervp_fwft_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 1R1W cell with a registered read port.
// The cell's read register doubles as the FIFO output register; total capacity is DEPTH+1.
module ervp_fwft_fifo_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BW_INDEX = $clog2(DEPTH),
  parameter int unsigned BW_COUNT = $clog2(DEPTH + 2)
) (
  input logic                  clk,
  input logic                  rst,
  ervp_fwft_fifo_ctrl_if.slave bus
);

  logic [BW_INDEX-1:0] wptr_q, wptr_d;
  logic [BW_INDEX-1:0] rptr_q, rptr_d;
  logic [BW_COUNT-1:0] mem_cnt_q, mem_cnt_d;
  logic                rvalid_q, rvalid_d;

  logic             wready;
  logic             push;
  logic             pop;
  logic             fetch;
  logic [WIDTH-1:0] wdata;

  assign wdata = bus.wdata;

  // wready depends on registered state only, so no rrequest->wready path.
  always_comb begin
    wready = (mem_cnt_q < BW_COUNT'(DEPTH));
    push   = bus.wrequest && wready && !bus.flush;
    pop    = bus.rrequest && rvalid_q && !bus.flush;
    // An empty memory with a push relies on the cell's same-index write forwarding.
    fetch  = !bus.flush && (!rvalid_q || pop) && ((mem_cnt_q != '0) || push);
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_cnt_d = mem_cnt_q;
    rvalid_d  = rvalid_q;
    if (bus.flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      mem_cnt_d = '0;
      rvalid_d  = 1'b0;
    end else begin
      if (push) begin
        wptr_d = (wptr_q == BW_INDEX'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (fetch) begin
        rptr_d = (rptr_q == BW_INDEX'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (fetch) begin
        rvalid_d = 1'b1;
      end else if (pop) begin
        rvalid_d = 1'b0;
      end
      mem_cnt_d = mem_cnt_q + BW_COUNT'(push) - BW_COUNT'(fetch);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_cnt_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    bus.wready      = wready;
    bus.rready      = rvalid_q;
    bus.rdata       = bus.mem_rdata_synch;
    bus.count       = mem_cnt_q + BW_COUNT'(rvalid_q);
    bus.mem_windex  = wptr_q;
    bus.mem_wenable = push;
    bus.mem_wdata   = wdata;
    bus.mem_rindex  = rptr_q;
    bus.mem_renable = fetch;
  end

endmodule

// File: tb/tb_ervp_fwft_fifo_ctrl.sv
// Bench for ervp_fwft_fifo_ctrl: DEPTH=4 and DEPTH=3 instances, each with a behavioural
// 1R1W cell, checked against a queue-based FIFO model.
module tb_ervp_fwft_fifo_ctrl;

  logic clk;
  logic rst;

  ervp_fwft_fifo_ctrl_if #(.WIDTH(32), .BW_INDEX(2), .BW_COUNT(3)) if4 ();
  ervp_fwft_fifo_ctrl_if #(.WIDTH(32), .BW_INDEX(2), .BW_COUNT(3)) if3 ();

  ervp_fwft_fifo_ctrl #(.DEPTH(4), .WIDTH(32)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  ervp_fwft_fifo_ctrl #(.DEPTH(3), .WIDTH(32)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory cells: registered read, same-index write forwarding, output held when idle.
  logic [31:0] mem4 [4];
  logic [31:0] mem3 [3];

  always @(posedge clk) begin
    if (if4.mem_wenable) mem4[if4.mem_windex] <= if4.mem_wdata;
    if (if4.mem_renable) begin
      if4.mem_rdata_synch <= (if4.mem_wenable && (if4.mem_windex == if4.mem_rindex)) ?
                             if4.mem_wdata : mem4[if4.mem_rindex];
    end
  end

  always @(posedge clk) begin
    if (if3.mem_wenable) mem3[if3.mem_windex] <= if3.mem_wdata;
    if (if3.mem_renable) begin
      if3.mem_rdata_synch <= (if3.mem_wenable && (if3.mem_windex == if3.mem_rindex)) ?
                             if3.mem_wdata : mem3[if3.mem_rindex];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the words held, in order, plus running push/fetch totals.
  logic [31:0] q[$];
  int          depth;
  int unsigned wcnt;
  int unsigned rcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wcnt = 0;
    rcnt = 0;
  endtask

  task automatic drive(input bit sel, input logic wreq, input logic [31:0] wd,
                       input logic rreq, input logic fl);
    if4.wrequest = 1'b0; if4.wdata = '0; if4.rrequest = 1'b0; if4.flush = 1'b0;
    if3.wrequest = 1'b0; if3.wdata = '0; if3.rrequest = 1'b0; if3.flush = 1'b0;
    if (sel == 1'b0) begin
      if4.wrequest = wreq; if4.wdata = wd; if4.rrequest = rreq; if4.flush = fl;
    end else begin
      if3.wrequest = wreq; if3.wdata = wd; if3.rrequest = rreq; if3.flush = fl;
    end
  endtask

  // One clock cycle: drive, check every output against the model, then advance the model.
  task automatic step(input bit sel, input logic wreq, input logic [31:0] wd,
                      input logic rreq, input logic fl, input string tag);
    logic        wr, rr, wen, ren;
    logic [31:0] rd, mwd;
    logic [31:0] cnt, win, rin;
    int          sz, sza;
    logic        exp_wr, exp_rr, push, pop, fetch;
    @(negedge clk);
    drive(sel, wreq, wd, rreq, fl);
    #1;
    if (sel == 1'b0) begin
      wr = if4.wready; rr = if4.rready; rd = if4.rdata; cnt = 32'(if4.count);
      wen = if4.mem_wenable; ren = if4.mem_renable; mwd = if4.mem_wdata;
      win = 32'(if4.mem_windex); rin = 32'(if4.mem_rindex);
    end else begin
      wr = if3.wready; rr = if3.rready; rd = if3.rdata; cnt = 32'(if3.count);
      wen = if3.mem_wenable; ren = if3.mem_renable; mwd = if3.mem_wdata;
      win = 32'(if3.mem_windex); rin = 32'(if3.mem_rindex);
    end
    sz     = q.size();
    exp_wr = (sz <= depth);
    exp_rr = (sz > 0);
    push   = wreq && exp_wr && !fl;
    pop    = rreq && exp_rr && !fl;
    sza    = sz - int'(pop) + int'(push);
    // A word enters the output register when it is empty or being vacated.
    fetch  = !fl && ((sz == 0) || pop) && (sza > 0);
    chk({tag, ":wready"}, 32'(wr), 32'(exp_wr));
    chk({tag, ":rready"}, 32'(rr), 32'(exp_rr));
    chk({tag, ":count"}, cnt, 32'(sz));
    if (exp_rr) chk({tag, ":rdata"}, rd, q[0]);
    chk({tag, ":wenable"}, 32'(wen), 32'(push));
    if (push) begin
      chk({tag, ":windex"}, win, wcnt % depth);
      chk({tag, ":mem_wdata"}, mwd, wd);
    end
    chk({tag, ":renable"}, 32'(ren), 32'(fetch));
    if (fetch) chk({tag, ":rindex"}, rin, rcnt % depth);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(wd);
        wcnt++;
      end
      if (fetch) rcnt++;
    end
  endtask

  task automatic async_reset(input bit sel, input string tag);
    logic [31:0] rr, cnt, win, rin, wr;
    @(negedge clk);
    drive(sel, 1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    if (sel == 1'b0) begin
      rr = 32'(if4.rready); cnt = 32'(if4.count); wr = 32'(if4.wready);
      win = 32'(if4.mem_windex); rin = 32'(if4.mem_rindex);
    end else begin
      rr = 32'(if3.rready); cnt = 32'(if3.count); wr = 32'(if3.wready);
      win = 32'(if3.mem_windex); rin = 32'(if3.mem_rindex);
    end
    chk({tag, ":rready"}, rr, 32'd0);
    chk({tag, ":count"}, cnt, 32'd0);
    chk({tag, ":wready"}, wr, 32'd1);
    chk({tag, ":windex"}, win, 32'd0);
    chk({tag, ":rindex"}, rin, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        wq, rq, fl;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_clear();
    depth = 4;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(0, 0, '0, 0, 0, "reset");

    // Single push into an empty FIFO, visible next cycle.
    step(0, 1, 32'hA5, 0, 0, "a5_push");
    step(0, 0, '0, 0, 0, "a5_head");
    step(0, 0, '0, 1, 0, "a5_pop");

    // Fill to DEPTH+1, overflow attempt, drain.
    for (int i = 1; i <= 5; i++) step(0, 1, 32'(i), 0, 0, "fill");
    step(0, 1, 32'h6, 0, 0, "overflow");
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 0, "drain");
    step(0, 0, '0, 1, 0, "empty_pop");

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) step(0, 1, 32'h20 + 32'(i), 0, 0, "pre_flush");
    step(0, 1, 32'hFF, 1, 1, "flush");
    step(0, 0, '0, 0, 0, "post_flush");
    chk("flush_dropped", 32'(if4.rdata === 32'hFF), 32'd0);

    // Asynchronous reset mid-stream, then recovery.
    for (int i = 0; i < 4; i++) step(0, 1, 32'h40 + 32'(i), i[0], 0, "stream");
    async_reset(0, "async_rst");
    step(0, 1, 32'h77, 0, 0, "x77_push");
    step(0, 0, '0, 1, 0, "x77_head");

    // DEPTH=3 streaming: push and pop every cycle.
    depth = 3;
    model_clear();
    for (int i = 0; i < 12; i++) step(1, 1, 32'h10 + 32'(i), 1, 0, "d3_stream");
    step(1, 0, '0, 1, 0, "d3_last");
    step(1, 0, '0, 0, 0, "d3_empty");

    // Randomised traffic on DEPTH=4: push-heavy then pop-heavy.
    depth = 4;
    async_reset(0, "rand_rst");
    for (int i = 0; i < 400; i++) begin
      d  = $urandom;
      wq = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rq = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 59) == 0);
      step(0, wq, d, rq, fl, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ervp_fwft_fifo_ctrl.md
Name: ervp_fwft_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO controller that drives a 1R1W memory cell with a registered read port and same-index write-to-read forwarding.
- Generates the write/read indices and enables, and exposes the cell's synchronous read register directly as the FIFO output register.
- Producer side: ready/request push interface. Consumer side: ready/request pop interface. No extra data storage in this block.

Parameters:
- DEPTH, 4, number of memory entries; any value ≥2, power of two not required.
- WIDTH, 32, data width.
- BW_INDEX, LOG2RU(DEPTH), width of memory index ports.
- BW_COUNT, LOG2RU(DEPTH+2), width of occupancy count (total capacity DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of FIFO state
- wready  out  1  push permitted
- wrequest  in  1  push strobe; push = wrequest && wready
- wdata  in  WIDTH  push data
- rready  out  1  output word valid
- rrequest  in  1  pop strobe; pop = rrequest && rready
- rdata  out  WIDTH  head word; equals mem_rdata_synch
- count  out  BW_COUNT  total words held (memory + output)
- mem_windex  out  BW_INDEX  write index to cell
- mem_wenable  out  1  write enable to cell
- mem_wdata  out  WIDTH  write data to cell (= wdata)
- mem_rindex  out  BW_INDEX  read index to cell
- mem_renable  out  1  read enable to cell
- mem_rdata_synch  in  WIDTH  cell registered read data; held while mem_renable=0

Behaviour:
- Clock clk only; rst asynchronous, active-high. Cell instantiated with USE_SUBWORD_ENABLE=0; its wpermit tied all-ones by the integrator.
- State: wptr, rptr (BW_INDEX, range 0..DEPTH-1), mem_cnt (0..DEPTH), rvalid (1 bit).
- Reset values: wptr=0, rptr=0, mem_cnt=0, rvalid=0. Hence wready=1, rready=0, count=0. Memory contents are don't-care.
- wready = (mem_cnt < DEPTH), decoded from registered state only; no combinational path from rrequest.
- push: mem_wenable=1, mem_windex=wptr. wptr advances with wrap: DEPTH-1 → 0.
- fetch = (!rvalid || pop) && (mem_cnt != 0 || push).
  - Forwarding in the cell covers the mem_cnt==0 && push case: rindex==windex and new data is returned.
- fetch: mem_renable=1, mem_rindex=rptr. rptr advances with the same wrap rule.
- rvalid next = fetch ? 1 : (pop ? 0 : rvalid).
- mem_cnt next = mem_cnt + push − fetch.
  - Both push and fetch in one cycle leave mem_cnt unchanged.
  - Never underflows: fetch requires mem_cnt>0 or push.
- count = mem_cnt + rvalid.
- rready = rvalid. rdata = mem_rdata_synch; valid only while rready=1.
- Latency:
  - Push into empty FIFO → rready=1 the next cycle.
  - Sustained push+pop every cycle → one word per cycle, no bubbles.
- Word order preserved strictly FIFO.
- Push while wready=0: ignored, no state change.
- rrequest while rready=0: ignored.
- flush:
  - Next state is the reset state.
  - Overrides push and pop in the same cycle; mem_wenable and mem_renable forced 0 that cycle.
  - A word offered that cycle is dropped.
- rst asserted mid-operation: all state clears immediately; outputs at reset values while rst=1.
- In the cell, mem_renable only when fetch; the output register is therefore stable across stalls (rvalid=1, rrequest=0).

Test Plan:
- Apply and release rst → wready=1, rready=0, count=0, mem_wenable=mem_renable=0.
- DEPTH=4, empty; push 0xA5 at cycle t → at t: mem_wenable=1, mem_renable=1, mem_windex=mem_rindex=0. At t+1: rready=1, rdata=0xA5, count=1.
- DEPTH=4, push 0x1..0x5 on consecutive cycles, no pops → all five accepted, then wready=0 and count=5. A 6th push is ignored. Popping 5 times yields 0x1..0x5; rready=0 afterwards.
- DEPTH=3, push and pop every cycle for 12 words (0x10..0x1B) → after one-cycle startup, rready stays 1. Data in order; pointers wrap 0,1,2,0…; count stays 1.
- Fill to count=3, then assert flush together with push 0xFF and pop → next cycle count=0, rready=0, wready=1; 0xFF never appears at rdata.
- Stream words, assert rst asynchronously between clock edges → rready, count and pointers clear immediately. After release, push 0x77 → rdata=0x77 one cycle later.
